// File: rtl/fetch_ctrl.sv
// Instruction-fetch stage: drives the Instr_Mem address, captures the returned word into
// the IF/ID register, and handles stalls, taken-branch redirects with squash, and HALT.
module fetch_ctrl #(
  parameter int                   PROG_CTR_WID = 10,
  parameter int                   INSTR_WID    = 16,
  parameter logic [INSTR_WID-1:0] HALT_INSTR   = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [PROG_CTR_WID-1:0] branch_target,
  input  logic [INSTR_WID-1:0]    instr_mem_out,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic [INSTR_WID-1:0]    if_id_instr,
  output logic [PROG_CTR_WID-1:0] if_id_pc,
  output logic                    if_id_valid,
  output logic                    halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [PROG_CTR_WID-1:0] prog_ctr_reg, prog_ctr_next;
  logic [INSTR_WID-1:0]    if_id_instr_reg, if_id_instr_next;
  logic [PROG_CTR_WID-1:0] if_id_pc_reg, if_id_pc_next;
  logic                    if_id_valid_reg, if_id_valid_next;
  logic                    halted_reg, halted_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      prog_ctr_reg    <= '0;
      if_id_instr_reg <= '0;
      if_id_pc_reg    <= '0;
      if_id_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prog_ctr_reg    <= prog_ctr_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_valid_reg <= if_id_valid_next;
      halted_reg      <= halted_next;
    end
  end

  // Priority: redirect beats everything (including stall and HALT), then HALT, then stall.
  always_comb begin
    state_next       = state_reg;
    prog_ctr_next    = prog_ctr_reg;
    if_id_instr_next = if_id_instr_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_valid_next = if_id_valid_reg;

    if (branch_taken) begin
      prog_ctr_next    = branch_target;
      if_id_valid_next = 1'b0;
      state_next       = RUN;
    end else if (state_reg == HALT) begin
      // A stall on the capture cycle keeps the HALT word visible to decode.
      if (!stall) begin
        if_id_valid_next = 1'b0;
      end
    end else if (!stall) begin
      if_id_instr_next = instr_mem_out;
      if_id_pc_next    = prog_ctr_reg;
      if_id_valid_next = 1'b1;
      if (instr_mem_out == HALT_INSTR) begin
        state_next = HALT;
      end else begin
        prog_ctr_next = prog_ctr_reg + 1'b1;
      end
    end

    halted_next = (state_next == HALT);
  end

  assign prog_ctr    = prog_ctr_reg;
  assign if_id_instr = if_id_instr_reg;
  assign if_id_pc    = if_id_pc_reg;
  assign if_id_valid = if_id_valid_reg;
  assign halted      = halted_reg;

endmodule
